// File: rtl/systolic_mm_engine.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier: buffers SIZE operand
// beats, skews them into the PE grid and accumulates C = A*B (or C + A*B) in place.
module systolic_mm_engine #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0]     a_col,
  input  logic [SIZE*DATA_WIDTH-1:0]     b_row,
  input  logic                           acc_mode,
  input  logic                           clear,
  output logic                           busy,
  output logic                           done,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0] C
);
  localparam int CNT_W  = $clog2(3*SIZE-2);
  localparam int BEAT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(3*SIZE-3);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SIZE-1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [BEAT_W-1:0]     r_beat;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_mode;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_first_clr;
  logic [DATA_WIDTH-1:0] r_a_buf  [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] r_b_buf  [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] r_a_pipe [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] r_b_pipe [SIZE][SIZE];
  logic [ACC_WIDTH-1:0]  r_acc    [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] w_a_in   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] w_b_in   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] w_west   [SIZE];
  logic [DATA_WIDTH-1:0] w_north  [SIZE];

  assign w_accept    = in_valid & r_in_ready;
  assign w_clear     = clear & (r_state == S_IDLE);
  assign w_first_clr = (r_cnt == '0) & ~r_mode;
  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;

  // Next-state decode for the run sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = w_accept ? S_LOAD : S_IDLE;
      S_LOAD:    w_state_nxt = (w_accept && (r_beat == BEAT_LAST)) ? S_COMPUTE : S_LOAD;
      S_COMPUTE: w_state_nxt = (r_cnt == CNT_LAST) ? S_DONE : S_COMPUTE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, beat/cycle counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
      end
      if (w_accept && (r_state == S_IDLE)) begin
        r_mode <= acc_mode;
      end
      if ((r_state == S_COMPUTE) && (r_cnt != CNT_LAST)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Operand buffer: beat k holds column k of A and row k of B
  always_ff @(posedge clk) begin
    for (int k = 0; k < SIZE; k++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (rst) begin
          r_a_buf[k][i] <= '0;
          r_b_buf[k][i] <= '0;
        end else if (w_accept && (r_beat == BEAT_W'(k))) begin
          r_a_buf[k][i] <= a_col[i*DATA_WIDTH +: DATA_WIDTH];
          r_b_buf[k][i] <= b_row[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Edge skew: row/column i sees beat k on compute cycle k+i, zero otherwise
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_west[i]  = '0;
      w_north[i] = '0;
      for (int k = 0; k < SIZE; k++) begin
        w_west[i]  = w_west[i]  | (((r_state == S_COMPUTE) && (r_cnt == CNT_W'(k + i))) ? r_a_buf[k][i] : '0);
        w_north[i] = w_north[i] | (((r_state == S_COMPUTE) && (r_cnt == CNT_W'(k + i))) ? r_b_buf[k][i] : '0);
      end
    end
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      if (gj == 0) begin : g_west_edge
        assign w_a_in[gi][gj] = w_west[gi];
      end else begin : g_west_pe
        assign w_a_in[gi][gj] = r_a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_north_edge
        assign w_b_in[gi][gj] = w_north[gj];
      end else begin : g_north_pe
        assign w_b_in[gi][gj] = r_b_pipe[gi-1][gj];
      end
      assign C[(gi*SIZE+gj)*ACC_WIDTH +: ACC_WIDTH] = r_acc[gi][gj];
    end
  end

  // PE grid: MAC into the stationary accumulator, forward A east and B south
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (rst) begin
          r_a_pipe[i][j] <= '0;
          r_b_pipe[i][j] <= '0;
          r_acc[i][j]    <= '0;
        end else if (r_state == S_COMPUTE) begin
          r_a_pipe[i][j] <= w_a_in[i][j];
          r_b_pipe[i][j] <= w_b_in[i][j];
          r_acc[i][j]    <= (w_first_clr ? '0 : r_acc[i][j])
                          + ACC_WIDTH'(w_a_in[i][j]) * ACC_WIDTH'(w_b_in[i][j]);
        end else begin
          r_a_pipe[i][j] <= '0;
          r_b_pipe[i][j] <= '0;
          if (w_clear) begin
            r_acc[i][j] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomized self-checking bench for systolic_mm_engine (SIZE=3, DATA_WIDTH=10),
// with a second instance at ACC_WIDTH=21 to exercise modulo wrap-around.
module tb_systolic_mm_engine;
  localparam int S   = 3;
  localparam int DW  = 10;
  localparam int AW  = 2*DW+8;
  localparam int AW2 = 21;

  typedef int mat_t [S][S];

  logic              clk = 1'b0;
  logic              rst, in_valid, acc_mode, clear;
  logic [S*DW-1:0]   a_col, b_row;
  logic              in_ready, busy, done;
  logic              in_ready2, busy2, done2;
  logic [S*S*AW-1:0]  c1;
  logic [S*S*AW2-1:0] c2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_acc, first_acc_cyc, last_done_cyc;

  // model state: phase 0 idle, 1 loading, 2 computing, 3 result presented
  int     m_ph = 0;
  int     m_k = 0;
  int     m_left = 0;
  bit     m_mode = 1'b0;
  longint m_c [S][S];
  longint m_nxt [S][S];
  int     m_a [S][S];
  int     m_b [S][S];

  always #5 clk = ~clk;

  systolic_mm_engine #(.SIZE(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .acc_mode(acc_mode), .clear(clear),
    .busy(busy), .done(done), .C(c1));

  systolic_mm_engine #(.SIZE(S), .DATA_WIDTH(DW), .ACC_WIDTH(AW2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a_col(a_col), .b_row(b_row), .acc_mode(acc_mode), .clear(clear),
    .busy(busy2), .done(done2), .C(c2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t e);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        chk($sformatf("%s C[%0d][%0d]", name, i, j), 64'(c1[(i*S+j)*AW +: AW]), 64'(e[i][j]));
  endtask

  task automatic chk_mat2(input string name, input mat_t e);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        chk($sformatf("%s C21[%0d][%0d]", name, i, j), 64'(c2[(i*S+j)*AW2 +: AW2]), 64'(e[i][j]));
  endtask

  // Reference model: C = (mode ? C : 0) + A*B mod 2^AW, visible 3S-2 edges after the last beat
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ph = 0;
      m_k  = 0;
      for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) m_c[i][j] = 0;
    end else begin
      case (m_ph)
        0, 1: begin
          if (m_ph == 0 && clear)
            for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) m_c[i][j] = 0;
          if (in_valid) begin
            if (m_k == 0) m_mode = acc_mode;
            for (int i = 0; i < S; i++) begin
              m_a[i][m_k] = int'(a_col[i*DW +: DW]);
              m_b[m_k][i] = int'(b_row[i*DW +: DW]);
            end
            m_k++;
            m_ph = 1;
            if (m_k == S) begin
              for (int i = 0; i < S; i++)
                for (int j = 0; j < S; j++) begin
                  m_nxt[i][j] = m_mode ? m_c[i][j] : 0;
                  for (int k = 0; k < S; k++) m_nxt[i][j] += longint'(m_a[i][k]) * longint'(m_b[k][j]);
                  m_nxt[i][j] &= (64'sd1 <<< AW) - 1;
                end
              m_ph = 2;
              m_k = 0;
              m_left = 3*S-2;
            end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 3;
            m_c = m_nxt;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("in_ready", in_ready, 64'(m_ph <= 1));
    chk("busy", busy, 64'(m_ph != 0));
    chk("done", done, 64'(m_ph == 3));
    chk("done21", done2, 64'(m_ph == 3));
    if (m_ph != 2) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          chk($sformatf("cyc C[%0d][%0d]", i, j), 64'(c1[(i*S+j)*AW +: AW]), 64'(m_c[i][j]));
          chk($sformatf("cyc C21[%0d][%0d]", i, j), 64'(c2[(i*S+j)*AW2 +: AW2]),
              64'(m_c[i][j] & ((64'sd1 <<< AW2) - 1)));
        end
    end
  end

  // Presents one run; caller must be at a negedge. Returns at the done negedge or after a reset pulse.
  task automatic run(input mat_t a, input mat_t b, input bit mode, input bit clr0,
                     input bit garbage, input int rst_after);
    int guard;
    for (int k = 0; k < S; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1'b1;
      acc_mode = (k == 0) ? mode : ~mode;
      clear    = (k == 0) ? clr0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < S; i++) begin
        a_col[i*DW +: DW] = DW'(a[i][k]);
        b_row[i*DW +: DW] = DW'(b[k][i]);
      end
      guard = 0;
      while (!in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      chk("ready_wait_bound", 64'(guard < 40), 64'd1);
      if (k == 0) first_acc_cyc = cyc + 1;
    end
    t_acc = cyc + 1;
    if (rst_after > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear = 1'b0;
      repeat (rst_after - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 64'd0);
      chk("rst_ready", in_ready, 64'd1);
    end else begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        if (garbage) begin
          in_valid = 1'b1;
          a_col    = (S*DW)'({$urandom, $urandom});
          b_row    = (S*DW)'({$urandom, $urandom});
          clear    = 1'($urandom_range(0, 1));
          acc_mode = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
          clear    = 1'b0;
        end
      end while (!done && guard < 30);
      in_valid = 1'b0;
      clear = 1'b0;
      chk("done_seen", done, 64'd1);
      chk("done_latency", 64'(cyc - t_acc), 64'd7);
      last_done_cyc = cyc;
    end
  endtask

  initial begin
    mat_t ma, mi, mz, m1k, e30, e31, e32, e32b, ra, rb;
    int d;
    ma  = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mi  = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mz  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    m1k = '{'{1023, 1023, 1023}, '{1023, 1023, 1023}, '{1023, 1023, 1023}};
    e30 = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    e31 = '{'{2, 4, 6}, '{8, 10, 12}, '{14, 16, 18}};
    e32 = '{'{3139587, 3139587, 3139587}, '{3139587, 3139587, 3139587}, '{3139587, 3139587, 3139587}};
    e32b = '{'{1042435, 1042435, 1042435}, '{1042435, 1042435, 1042435}, '{1042435, 1042435, 1042435}};

    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; acc_mode = 1'b0;
    a_col = '0; b_row = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_mat("reset", mz);
    chk("reset_done", done, 64'd0);

    @(negedge clk); run(ma, mi, 1'b0, 1'b0, 1'b0, 0); chk_mat("A*I", ma);
    @(negedge clk); run(ma, ma, 1'b0, 1'b0, 1'b0, 0); chk_mat("A*A", e30);
    @(negedge clk); run(ma, mi, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk); run(ma, mi, 1'b1, 1'b0, 1'b0, 0); chk_mat("acc A*I", e31);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; chk_mat("clear", mz);

    run(m1k, m1k, 1'b0, 1'b0, 1'b0, 0);
    chk_mat("all1023", e32);
    chk_mat2("all1023", e32b);

    @(negedge clk); run(ma, ma, 1'b0, 1'b0, 1'b1, 0); chk_mat("garbage", e30);
    d = last_done_cyc;
    run(ma, mi, 1'b0, 1'b0, 1'b0, 0); chk_mat("back2back", ma);
    chk("b2b_first_beat", 64'(first_acc_cyc - d), 64'd2);

    @(negedge clk); run(ma, ma, 1'b0, 1'b0, 1'b0, 4); chk_mat("mid_rst", mz);
    run(ma, ma, 1'b0, 1'b0, 1'b0, 0); chk_mat("after_rst", e30);

    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          ra[i][j] = (r % 4 == 0) ? 1023 : int'($urandom_range(0, 1023));
          rb[i][j] = (r % 4 == 0) ? 1023 : int'($urandom_range(0, 1023));
        end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        clear = 1'($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      run(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
